npc_ctrl_fsm: RTL

//  Multi-cycle sequencer for the single-issue RV64 NPC core. Owns the PC, fetches one

---
 rtl/npc_ctrl_fsm_if.sv | 23 ++
 rtl/npc_ctrl_fsm.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/npc_ctrl_fsm_if.sv
// Fetch and data-memory handshake bundle between the NPC sequencer and the memory side.
// The sequencer is the master: it issues requests and the memory side returns ack/data.
interface npc_ctrl_fsm_if #(
    parameter int XLEN = 64
);
    logic            ifu_req;
    logic [XLEN-1:0] ifu_addr;
    logic            ifu_ack;
    logic [31:0]     ifu_rdata;
    logic            lsu_req;
    logic            lsu_we;
    logic            lsu_ack;

    modport master (
        output ifu_req, ifu_addr, lsu_req, lsu_we,
        input  ifu_ack, ifu_rdata, lsu_ack
    );

    modport slave (
        input  ifu_req, ifu_addr, lsu_req, lsu_we,
        output ifu_ack, ifu_rdata, lsu_ack
    );
endinterface

// File: rtl/npc_ctrl_fsm.sv
// Multi-cycle sequencer for the single-issue RV64 NPC core: owns the PC, fetches and
// latches one instruction at a time, and steps the execute/store/writeback phases.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | one cycle after reset release
// S_FETCH  | ifu_req high, waiting for ifu_ack (timeout -> halt 11)
// S_DECODE | check illegal / ebreak / misaligned jump
// S_EXEC   | ALU settles; stores go to S_MEM, everything else to S_WB
// S_MEM    | lsu_req high, waiting for lsu_ack (timeout -> halt 11)
// S_WB     | rf_wen pulse, PC update, instret increment
// S_HALT   | sticky stop, left only through reset
module npc_ctrl_fsm #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = 'h8000_0000,
    parameter int              TIMEOUT  = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    npc_ctrl_fsm_if.master  bus,
    output logic [31:0]     inst_o,
    input  logic            dec_reg_wen_i,
    input  logic            dec_mem_wen_i,
    input  logic            dec_is_jal_i,
    input  logic            dec_is_ebreak_i,
    input  logic            dec_inst_not_ipl_i,
    input  logic [XLEN-1:0] br_target_i,
    output logic            rf_wen_o,
    output logic [XLEN-1:0] pc_o,
    output logic [63:0]     instret_o,
    output logic            halt_o,
    output logic [1:0]      halt_code_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_e;

    // last wait count before giving up; the counter is 8 bits wide
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_e          state_q, state_d;
    logic [7:0]      wait_q, wait_d;
    logic [1:0]      halt_code_q, halt_code_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [31:0]     inst_q, inst_d;
    logic [63:0]     instret_q, instret_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wait_q      <= 8'd0;
            halt_code_q <= 2'b00;
            pc_q        <= RESET_PC;
            inst_q      <= 32'd0;
            instret_q   <= 64'd0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            halt_code_q <= halt_code_d;
            pc_q        <= pc_d;
            inst_q      <= inst_d;
            instret_q   <= instret_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        halt_code_d = halt_code_q;
        case (state_q)
            S_IDLE:   state_d = S_FETCH;
            S_FETCH: begin
                if (bus.ifu_ack) begin
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    state_d     = S_HALT;
                    halt_code_d = 2'b11;
                end
            end
            S_DECODE: begin
                if (dec_inst_not_ipl_i) begin
                    state_d     = S_HALT;
                    halt_code_d = 2'b10;
                end else if (dec_is_ebreak_i) begin
                    state_d     = S_HALT;
                    halt_code_d = 2'b01;
                end else if (dec_is_jal_i && (br_target_i[1:0] != 2'b00)) begin
                    state_d     = S_HALT;
                    halt_code_d = 2'b10;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC:   state_d = dec_mem_wen_i ? S_MEM : S_WB;
            S_MEM: begin
                if (bus.lsu_ack) begin
                    state_d = S_WB;
                end else if (wait_q == WAIT_LAST) begin
                    state_d     = S_HALT;
                    halt_code_d = 2'b11;
                end
            end
            S_WB:     state_d = S_FETCH;
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase

        // counter only runs while parked in a waiting state; any state entry clears it
        wait_d = 8'd0;
        if ((state_q == S_FETCH || state_q == S_MEM) && state_d == state_q) begin
            wait_d = wait_q + 8'd1;
        end
    end

    always_comb begin
        pc_d      = pc_q;
        inst_d    = inst_q;
        instret_d = instret_q;
        if (state_q == S_FETCH && bus.ifu_ack) begin
            inst_d = bus.ifu_rdata;
        end
        if (state_q == S_WB) begin
            pc_d      = dec_is_jal_i ? br_target_i : pc_q + XLEN'(4);
            instret_d = instret_q + 64'd1;
        end
    end

    always_comb begin
        bus.ifu_req = 1'b0;
        bus.lsu_req = 1'b0;
        bus.lsu_we  = 1'b0;
        rf_wen_o    = 1'b0;
        halt_o      = 1'b0;
        case (state_q)
            S_FETCH: bus.ifu_req = 1'b1;
            S_MEM: begin
                bus.lsu_req = 1'b1;
                bus.lsu_we  = dec_mem_wen_i;
            end
            S_WB:    rf_wen_o = dec_reg_wen_i;
            S_HALT:  halt_o   = 1'b1;
            default: ;
        endcase
    end

    assign bus.ifu_addr = pc_q;
    assign pc_o         = pc_q;
    assign inst_o       = inst_q;
    assign instret_o    = instret_q;
    assign halt_code_o  = halt_code_q;
endmodule
